// File: rtl/mem_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_request_ctrl
// Description : Arbitrates core fetch and load/store requests onto separate
//               instruction and data memory ports with fixed 3-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_request_ctrl #(
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        mem_Clk,
    input  logic        Rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        fetch_done,
    output logic [31:0] fetch_instr,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        addr_err,
    output logic        busy,
    output logic        instruction_memory_en,
    output logic [31:0] instruction_memory_a,
    input  logic [31:0] instruction_memory_v,
    output logic [31:0] data_memory_a,
    output logic        data_memory_read,
    output logic        data_memory_write,
    output logic [31:0] data_memory_out_v,
    input  logic [31:0] data_memory_in_v
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_F_ISSUE = 3'd1;
    localparam logic [2:0] S_F_CAPT  = 3'd2;
    localparam logic [2:0] S_L_ISSUE = 3'd3;
    localparam logic [2:0] S_L_CAPT  = 3'd4;
    localparam logic [2:0] S_S_ISSUE = 3'd5;
    localparam logic [2:0] S_S_DONE  = 3'd6;

    localparam logic [32:0] c_MEM_LIMIT = 33'(MEM_BYTES);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        w_sample;
    logic        w_ls_go;
    logic        w_f_go;
    logic        w_ls_bad;
    logic        w_f_bad;

    logic        r_fetch_done;
    logic [31:0] r_fetch_instr;
    logic        r_ls_done;
    logic [31:0] r_ls_rdata;
    logic        r_addr_err;
    logic        r_imem_en;
    logic [31:0] r_imem_a;
    logic [31:0] r_dmem_a;
    logic        r_dmem_read;
    logic        r_dmem_write;
    logic [31:0] r_dmem_out_v;

    // The 33-bit sum keeps addresses near 2^32 from wrapping back into range.
    assign w_ls_bad = (ls_addr[1:0] != 2'b00)
                   || (({1'b0, ls_addr} + 33'd3) >= c_MEM_LIMIT);
    assign w_f_bad  = (fetch_pc[1:0] != 2'b00)
                   || (({1'b0, fetch_pc} + 33'd3) >= c_MEM_LIMIT);

    // No sampling during a done cycle: the core is still dropping its request.
    assign w_sample = (r_state == S_IDLE) && !r_fetch_done && !r_ls_done;
    assign w_ls_go  = w_sample && ls_req;
    assign w_f_go   = w_sample && fetch_req && !ls_req;

    always_ff @(posedge mem_Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_ls_go && !w_ls_bad) begin
                    w_next_state = ls_we ? S_S_ISSUE : S_L_ISSUE;
                end else if (w_f_go && !w_f_bad) begin
                    w_next_state = S_F_ISSUE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_F_ISSUE: w_next_state = S_F_CAPT;
            S_F_CAPT:  w_next_state = S_IDLE;
            S_L_ISSUE: w_next_state = S_L_CAPT;
            S_L_CAPT:  w_next_state = S_IDLE;
            S_S_ISSUE: w_next_state = S_S_DONE;
            S_S_DONE:  w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Every output register is updated on the edge that leaves the current state.
    always_ff @(posedge mem_Clk or posedge Rst) begin
        if (Rst) begin
            r_fetch_done  <= 1'b0;
            r_fetch_instr <= 32'd0;
            r_ls_done     <= 1'b0;
            r_ls_rdata    <= 32'd0;
            r_addr_err    <= 1'b0;
            r_imem_en     <= 1'b0;
            r_imem_a      <= 32'd0;
            r_dmem_a      <= 32'd0;
            r_dmem_read   <= 1'b0;
            r_dmem_write  <= 1'b0;
            r_dmem_out_v  <= 32'd0;
        end else begin
            r_fetch_done <= 1'b0;
            r_ls_done    <= 1'b0;
            r_addr_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ls_go) begin
                        if (w_ls_bad) begin
                            r_ls_done  <= 1'b1;
                            r_addr_err <= 1'b1;
                        end else begin
                            r_dmem_a <= ls_addr;
                            if (ls_we) begin
                                r_dmem_write <= 1'b1;
                                r_dmem_out_v <= ls_wdata;
                            end else begin
                                r_dmem_read <= 1'b1;
                            end
                        end
                    end else if (w_f_go) begin
                        if (w_f_bad) begin
                            r_fetch_done <= 1'b1;
                            r_addr_err   <= 1'b1;
                        end else begin
                            r_imem_en <= 1'b1;
                            r_imem_a  <= fetch_pc;
                        end
                    end
                end
                S_F_CAPT: begin
                    r_imem_en     <= 1'b0;
                    r_fetch_instr <= instruction_memory_v;
                    r_fetch_done  <= 1'b1;
                end
                S_L_CAPT: begin
                    r_dmem_read <= 1'b0;
                    r_ls_rdata  <= data_memory_in_v;
                    r_ls_done   <= 1'b1;
                end
                S_S_ISSUE: begin
                    r_dmem_write <= 1'b0;
                end
                S_S_DONE: begin
                    r_ls_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy                  = (r_state != S_IDLE);
    assign fetch_done            = r_fetch_done;
    assign fetch_instr           = r_fetch_instr;
    assign ls_done               = r_ls_done;
    assign ls_rdata              = r_ls_rdata;
    assign addr_err              = r_addr_err;
    assign instruction_memory_en = r_imem_en;
    assign instruction_memory_a  = r_imem_a;
    assign data_memory_a         = r_dmem_a;
    assign data_memory_read      = r_dmem_read;
    assign data_memory_write     = r_dmem_write;
    assign data_memory_out_v     = r_dmem_out_v;

endmodule
`default_nettype wire

// File: tb/tb_mem_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_request_ctrl
// Description : Directed self-checking bench for mem_request_ctrl with a
//               big-endian byte memory model behind both memory ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_request_ctrl;

    logic        mem_Clk;
    logic        Rst;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        fetch_done;
    logic [31:0] fetch_instr;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        addr_err;
    logic        busy;
    logic        instruction_memory_en;
    logic [31:0] instruction_memory_a;
    logic [31:0] instruction_memory_v;
    logic [31:0] data_memory_a;
    logic        data_memory_read;
    logic        data_memory_write;
    logic [31:0] data_memory_out_v;
    logic [31:0] data_memory_in_v;

    logic [7:0]  mem [0:65535];
    logic [15:0] w_ia;
    logic [15:0] w_da;
    logic        overlap_seen = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_request_ctrl #(.MEM_BYTES(65536)) dut (
        .mem_Clk               (mem_Clk),
        .Rst                   (Rst),
        .fetch_req             (fetch_req),
        .fetch_pc              (fetch_pc),
        .ls_req                (ls_req),
        .ls_we                 (ls_we),
        .ls_addr               (ls_addr),
        .ls_wdata              (ls_wdata),
        .fetch_done            (fetch_done),
        .fetch_instr           (fetch_instr),
        .ls_done               (ls_done),
        .ls_rdata              (ls_rdata),
        .addr_err              (addr_err),
        .busy                  (busy),
        .instruction_memory_en (instruction_memory_en),
        .instruction_memory_a  (instruction_memory_a),
        .instruction_memory_v  (instruction_memory_v),
        .data_memory_a         (data_memory_a),
        .data_memory_read      (data_memory_read),
        .data_memory_write     (data_memory_write),
        .data_memory_out_v     (data_memory_out_v),
        .data_memory_in_v      (data_memory_in_v)
    );

    initial begin
        mem_Clk = 1'b0;
        forever #5 mem_Clk = ~mem_Clk;
    end

    // Memory drives all-ones on the fetch port while the enable is low.
    assign w_ia = instruction_memory_a[15:0];
    assign w_da = data_memory_a[15:0];
    assign instruction_memory_v = instruction_memory_en
        ? {mem[w_ia], mem[w_ia + 16'd1], mem[w_ia + 16'd2], mem[w_ia + 16'd3]}
        : 32'hFFFF_FFFF;
    assign data_memory_in_v =
        {mem[w_da], mem[w_da + 16'd1], mem[w_da + 16'd2], mem[w_da + 16'd3]};

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        {mem[16'h0010], mem[16'h0011], mem[16'h0012], mem[16'h0013]} = 32'h1234_5678;
        {mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]} = 32'hA1B2_C3D4;
        {mem[16'hFFFC], mem[16'hFFFD], mem[16'hFFFE], mem[16'hFFFF]} = 32'hCAFE_BABE;
        forever begin
            @(negedge mem_Clk);
            if (data_memory_write === 1'b1)
                {mem[w_da], mem[w_da + 16'd1], mem[w_da + 16'd2], mem[w_da + 16'd3]} = data_memory_out_v;
        end
    end

    always @(negedge mem_Clk) begin
        if ((int'(instruction_memory_en) + int'(data_memory_read) + int'(data_memory_write)) > 1)
            overlap_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge mem_Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; fetch_req = 1'b0; fetch_pc = 32'd0; ls_req = 1'b0;
        ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0;
        tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b exp 0", busy); end
        n_cmp++; if ({fetch_done, ls_done, addr_err} !== 3'b000) begin n_bad++; $display("FAIL rst_done: got %b exp 000", {fetch_done, ls_done, addr_err}); end
        n_cmp++; if ({instruction_memory_en, data_memory_read, data_memory_write} !== 3'b000) begin n_bad++; $display("FAIL rst_strobes: got %b exp 000", {instruction_memory_en, data_memory_read, data_memory_write}); end
        n_cmp++; if ((fetch_instr | ls_rdata | instruction_memory_a | data_memory_a | data_memory_out_v) !== 32'd0) begin n_bad++; $display("FAIL rst_words: got nonzero %h %h %h %h %h exp 0", fetch_instr, ls_rdata, instruction_memory_a, data_memory_a, data_memory_out_v); end
        Rst = 1'b0;
    endtask

    task automatic test_fetch();
        // Request goes up with reset release; the next edge must accept it.
        fetch_pc = 32'h0000_0010; fetch_req = 1'b1;
        tick();
        n_cmp++; if (instruction_memory_en !== 1'b1) begin n_bad++; $display("FAIL fetch_en_c1: got %b exp 1", instruction_memory_en); end
        n_cmp++; if (instruction_memory_a !== 32'h10) begin n_bad++; $display("FAIL fetch_a_c1: got %h exp 00000010", instruction_memory_a); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fetch_busy_c1: got %b exp 1", busy); end
        fetch_pc = 32'h0000_0ABC;
        tick();
        n_cmp++; if ({instruction_memory_en, fetch_done} !== 2'b10) begin n_bad++; $display("FAIL fetch_c2: got en,done=%b exp 10", {instruction_memory_en, fetch_done}); end
        n_cmp++; if (instruction_memory_a !== 32'h10) begin n_bad++; $display("FAIL fetch_a_c2: got %h exp 00000010", instruction_memory_a); end
        tick();
        n_cmp++; if ({fetch_done, addr_err, instruction_memory_en, busy} !== 4'b1000) begin n_bad++; $display("FAIL fetch_c3: got done,err,en,busy=%b exp 1000", {fetch_done, addr_err, instruction_memory_en, busy}); end
        n_cmp++; if (fetch_instr !== 32'h1234_5678) begin n_bad++; $display("FAIL fetch_instr: got %h exp 12345678", fetch_instr); end
        fetch_req = 1'b0;
        tick();
        n_cmp++; if (fetch_done !== 1'b0) begin n_bad++; $display("FAIL fetch_done_pulse: got %b exp 0", fetch_done); end
        n_cmp++; if (fetch_instr !== 32'h1234_5678) begin n_bad++; $display("FAIL fetch_instr_hold: got %h exp 12345678", fetch_instr); end
        // Highest in-range aligned address.
        fetch_pc = 32'h0000_FFFC; fetch_req = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if ({fetch_done, addr_err} !== 2'b10) begin n_bad++; $display("FAIL fetch_top_done: got done,err=%b exp 10", {fetch_done, addr_err}); end
        n_cmp++; if (fetch_instr !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL fetch_top_instr: got %h exp cafebabe", fetch_instr); end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_store_load();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF;
        tick();
        n_cmp++; if ({data_memory_write, data_memory_read, instruction_memory_en} !== 3'b100) begin n_bad++; $display("FAIL st_c1_strobes: got w,r,en=%b exp 100", {data_memory_write, data_memory_read, instruction_memory_en}); end
        n_cmp++; if (data_memory_a !== 32'h100) begin n_bad++; $display("FAIL st_c1_a: got %h exp 00000100", data_memory_a); end
        n_cmp++; if (data_memory_out_v !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL st_c1_data: got %h exp deadbeef", data_memory_out_v); end
        ls_addr = 32'h104; ls_wdata = 32'h0; ls_we = 1'b0;
        tick();
        n_cmp++; if ({data_memory_write, ls_done, busy} !== 3'b001) begin n_bad++; $display("FAIL st_c2: got w,done,busy=%b exp 001", {data_memory_write, ls_done, busy}); end
        n_cmp++; if (data_memory_a !== 32'h100) begin n_bad++; $display("FAIL st_c2_a: got %h exp 00000100", data_memory_a); end
        tick();
        n_cmp++; if ({ls_done, addr_err, busy} !== 3'b100) begin n_bad++; $display("FAIL st_c3: got done,err,busy=%b exp 100", {ls_done, addr_err, busy}); end
        n_cmp++; if ({mem[16'h100], mem[16'h101], mem[16'h102], mem[16'h103]} !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL st_mem: got %h exp deadbeef", {mem[16'h100], mem[16'h101], mem[16'h102], mem[16'h103]}); end
        ls_req = 1'b0;
        tick();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
        tick();
        n_cmp++; if ({data_memory_read, data_memory_write} !== 2'b10) begin n_bad++; $display("FAIL ld_c1: got r,w=%b exp 10", {data_memory_read, data_memory_write}); end
        tick();
        n_cmp++; if ({data_memory_read, ls_done} !== 2'b10) begin n_bad++; $display("FAIL ld_c2: got r,done=%b exp 10", {data_memory_read, ls_done}); end
        tick();
        n_cmp++; if ({ls_done, addr_err, data_memory_read} !== 3'b100) begin n_bad++; $display("FAIL ld_c3: got done,err,r=%b exp 100", {ls_done, addr_err, data_memory_read}); end
        n_cmp++; if (ls_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ld_rdata: got %h exp deadbeef", ls_rdata); end
        ls_req = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        fetch_req = 1'b1; fetch_pc = 32'h10;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
        tick();
        n_cmp++; if ({data_memory_read, instruction_memory_en} !== 2'b10) begin n_bad++; $display("FAIL pri_c1: got r,en=%b exp 10", {data_memory_read, instruction_memory_en}); end
        tick(); tick();
        n_cmp++; if ({ls_done, fetch_done, instruction_memory_en} !== 3'b100) begin n_bad++; $display("FAIL pri_ls_done: got lsd,fd,en=%b exp 100", {ls_done, fetch_done, instruction_memory_en}); end
        n_cmp++; if (ls_rdata !== 32'hA1B2_C3D4) begin n_bad++; $display("FAIL pri_rdata: got %h exp a1b2c3d4", ls_rdata); end
        ls_req = 1'b0;
        tick();
        n_cmp++; if ({instruction_memory_en, busy} !== 2'b00) begin n_bad++; $display("FAIL pri_gap: got en,busy=%b exp 00", {instruction_memory_en, busy}); end
        tick();
        n_cmp++; if (instruction_memory_en !== 1'b1) begin n_bad++; $display("FAIL pri_fetch_en: got %b exp 1", instruction_memory_en); end
        tick(); tick();
        n_cmp++; if ({fetch_done, addr_err} !== 2'b10) begin n_bad++; $display("FAIL pri_fetch_done: got done,err=%b exp 10", {fetch_done, addr_err}); end
        n_cmp++; if (fetch_instr !== 32'h1234_5678) begin n_bad++; $display("FAIL pri_instr: got %h exp 12345678", fetch_instr); end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_errors();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h102;
        tick();
        n_cmp++; if ({ls_done, addr_err, data_memory_read, busy} !== 4'b1100) begin n_bad++; $display("FAIL err_mis: got done,err,r,busy=%b exp 1100", {ls_done, addr_err, data_memory_read, busy}); end
        n_cmp++; if (ls_rdata !== 32'hA1B2_C3D4) begin n_bad++; $display("FAIL err_rdata_hold: got %h exp a1b2c3d4", ls_rdata); end
        ls_req = 1'b0;
        tick();
        n_cmp++; if ({ls_done, addr_err} !== 2'b00) begin n_bad++; $display("FAIL err_clear: got done,err=%b exp 00", {ls_done, addr_err}); end
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0001_0000; ls_wdata = 32'h1111_1111;
        tick();
        n_cmp++; if ({ls_done, addr_err, data_memory_write} !== 3'b110) begin n_bad++; $display("FAIL err_oor: got done,err,w=%b exp 110", {ls_done, addr_err, data_memory_write}); end
        ls_req = 1'b0;
        tick();
        fetch_req = 1'b1; fetch_pc = 32'h0000_FFFE;
        tick();
        n_cmp++; if ({fetch_done, addr_err, instruction_memory_en} !== 3'b110) begin n_bad++; $display("FAIL err_fetch: got done,err,en=%b exp 110", {fetch_done, addr_err, instruction_memory_en}); end
        n_cmp++; if (fetch_instr !== 32'h1234_5678) begin n_bad++; $display("FAIL err_instr_hold: got %h exp 12345678", fetch_instr); end
        fetch_req = 1'b0;
        tick();
        n_cmp++; if ({fetch_done, addr_err, instruction_memory_en} !== 3'b000) begin n_bad++; $display("FAIL err_fetch_clear: got done,err,en=%b exp 000", {fetch_done, addr_err, instruction_memory_en}); end
    endtask

    task automatic test_reset_mid_store();
        logic stray;
        stray = 1'b0;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300; ls_wdata = 32'h55AA_55AA;
        tick();
        n_cmp++; if (data_memory_write !== 1'b1) begin n_bad++; $display("FAIL rms_issue: got w=%b exp 1", data_memory_write); end
        #2 Rst = 1'b1;
        #1;
        n_cmp++; if ({data_memory_write, busy, ls_done} !== 3'b000) begin n_bad++; $display("FAIL rms_async: got w,busy,done=%b exp 000", {data_memory_write, busy, ls_done}); end
        n_cmp++; if ((data_memory_a | data_memory_out_v | fetch_instr) !== 32'd0) begin n_bad++; $display("FAIL rms_words: got %h %h %h exp 0", data_memory_a, data_memory_out_v, fetch_instr); end
        ls_req = 1'b0;
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ls_done || busy || data_memory_write || data_memory_read || instruction_memory_en) stray = 1'b1;
        end
        n_cmp++; if (stray !== 1'b0) begin n_bad++; $display("FAIL rms_stray: got activity=%b exp 0", stray); end
        n_cmp++; if ({mem[16'h300], mem[16'h301], mem[16'h302], mem[16'h303]} !== 32'h0) begin n_bad++; $display("FAIL rms_mem: got %h exp 00000000", {mem[16'h300], mem[16'h301], mem[16'h302], mem[16'h303]}); end
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
        tick();
        n_cmp++; if (data_memory_read !== 1'b1) begin n_bad++; $display("FAIL rms_ld_c1: got r=%b exp 1", data_memory_read); end
        tick(); tick();
        n_cmp++; if ({ls_done, addr_err} !== 2'b10) begin n_bad++; $display("FAIL rms_ld_done: got done,err=%b exp 10", {ls_done, addr_err}); end
        n_cmp++; if (ls_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rms_ld_rdata: got %h exp deadbeef", ls_rdata); end
        ls_req = 1'b0;
        tick();
        n_cmp++; if (overlap_seen !== 1'b0) begin n_bad++; $display("FAIL strobe_overlap: got %b exp 0", overlap_seen); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_priority();
        test_errors();
        test_reset_mid_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
